lsu_sized: RTL
==============

// Module: lsu_sized
// PURPOSE
//  Parametrised load-store unit: byte/half/word loads and stores with sign/zero extension into a
//  byte-addressed data memory plus memory-mapped output peripherals (HEX, LEDR, LEDG, LCD) and a
//  synchronised switch input. Sits between the core's execute stage and the board I/O.
//  Registered load path (1-cycle latency with valid), misaligned-access detection.
// PARAMETERS
//  ADDR_W      12      byte-address width
//  DMEM_BYTES  2048    data memory size in bytes; power of two, must be <= IO_BASE
//  NUM_HEX     8       number of HEX output registers, 1..8
//  IO_BASE     'h800   base of output-peripheral window
//  SW_ADDR     'h900   address of switch input register; must exceed IO_BASE+'hA3
// PORTS
//  clk_i       in   1            clock, rising edge
//  rst_i       in   1            asynchronous reset, active-high
//  req_i       in   1            access request valid this cycle
//  st_en_i     in   1            1 = store, 0 = load (qualified by req_i)
//  addr_i      in   ADDR_W       byte address
//  size_i      in   2            00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
//  unsigned_i  in   1            loads: 1 = zero-extend, 0 = sign-extend
//  st_data_i   in   32           store data, right-aligned (byte in [7:0], half in [15:0])
//  io_sw_i     in   32           asynchronous switch inputs
//  ld_data_o   out  32           load result, extended
//  ld_valid_o  out  1            ld_data_o valid (one-cycle pulse)
//  misalign_o  out  1            one-cycle pulse: previous request was misaligned/reserved size
//  io_hex_o    out  NUM_HEX*32   HEX registers, HEX k in [32k+31:32k]
//  io_ledr_o   out  32           LEDR register
//  io_ledg_o   out  32           LEDG register
//  io_lcd_o    out  32           LCD register
// BEHAVIOUR
//  - Reset (async on rst_i high): all I/O registers, ld_data_o, ld_valid_o, misalign_o, switch
//    synchroniser = 0. Data memory is NOT reset. Reset mid-load squashes the pending ld_valid_o.
//  - Map: [0, DMEM_BYTES) dmem; IO_BASE+'h10*k (k<NUM_HEX) HEX k; IO_BASE+'h80 LEDR; +'h90 LEDG;
//    +'hA0 LCD; SW_ADDR switches (read-only). Each I/O register occupies the 4 bytes whose
//    addr[3:2]==0 of its 16-byte slot; everything else is unmapped.
//  - Alignment: half needs addr[0]==0, word needs addr[1:0]==0, size 11 always misaligned.
//    Misaligned request: no state change; misalign_o=1 next cycle; if load, ld_valid_o=1, ld_data_o=0.
//  - Store (req_i & st_en_i, aligned): byte lanes selected by addr[1:0] and size written at the
//    rising edge; little-endian (st_data_i[7:0] to lowest address). Unmapped/SW_ADDR: ignored,
//    no error. ld_valid_o stays 0.
//  - Load (req_i & ~st_en_i, aligned): data registered; ld_valid_o=1 and ld_data_o valid in the
//    cycle after req_i. Lane extracted by addr[1:0], extended per unsigned_i. Unmapped reads 0.
//  - Output registers readable back via loads; outputs reflect store from the following cycle.
//  - io_sw_i passes a 2-flop synchroniser; SW_ADDR loads return the synchronised value
//    (change on io_sw_i visible to a load issued >=2 cycles later).
//  - Back-to-back: store at cycle N then load same address at N+1 returns new data at N+2.
//    Accepts one request every cycle; no stall. ld_data_o holds last value when ld_valid_o=0.
//  - Addresses wrap modulo 2^ADDR_W; no access ever spans two words.
// TESTING
//  1. rst_i pulse mid-load (req at cycle N, reset during N..N+1) -> ld_valid_o never rises, all
//     I/O outputs 0.
//  2. sw 'h000<-'hDEADBEEF; lb 'h003 -> 'hFFFFFFDE; lbu 'h003 -> 'h000000DE; lh 'h000 ->
//     'hFFFFBEEF; lw 'h000 -> 'hDEADBEEF, each valid 1 cycle after request.
//  3. sb 'h005<-'hAA over word 'h11223344 at 'h004 -> lw 'h004 = 'h1122AA44.
//  4. sw 'h830<-'h12345678 -> io_hex_o[127:96]='h12345678 next cycle; lw 'h830 returns it;
//     sw 'h834 ignored (unmapped).
//  5. lw 'h002, lh 'h001, size 11 at 'h000 -> each: misalign_o=1, ld_valid_o=1, ld_data_o=0,
//     memory unchanged; sw 'h001 -> misalign_o=1, no write.
//  6. io_sw_i='hCAFE0001 then lw SW_ADDR at +1 cycle -> old value; at +2 -> 'hCAFE0001.

Source files
------------

// File: rtl/lsu_sized_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sized_if
// Brief    : Request/response bundle between the execute stage and the LSU.
// Revision : 1.0
// ============================================================================
interface lsu_sized_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req_i;
    logic              st_en_i;
    logic [ADDR_W-1:0] addr_i;
    logic [1:0]        size_i;
    logic              unsigned_i;
    logic [31:0]       st_data_i;
    logic [31:0]       ld_data_o;
    logic              ld_valid_o;
    logic              misalign_o;

    modport master (
        output req_i, st_en_i, addr_i, size_i, unsigned_i, st_data_i,
        input  ld_data_o, ld_valid_o, misalign_o
    );

    modport slave (
        input  req_i, st_en_i, addr_i, size_i, unsigned_i, st_data_i,
        output ld_data_o, ld_valid_o, misalign_o
    );
endinterface
`default_nettype wire

// File: rtl/lsu_sized.sv
`default_nettype none
// ============================================================================
// Module   : lsu_sized
// Brief    : Byte/half/word load-store unit over data memory, output
//            peripherals and a synchronised switch register.
// Revision : 1.0
// ============================================================================
module lsu_sized #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DMEM_BYTES = 2048,
    parameter int unsigned NUM_HEX    = 8,
    parameter int unsigned IO_BASE    = 'h800,
    parameter int unsigned SW_ADDR    = 'h900
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    lsu_sized_if.slave              bus,
    input  wire logic [31:0]        io_sw_i,
    output logic [NUM_HEX*32-1:0]   io_hex_o,
    output logic [31:0]             io_ledr_o,
    output logic [31:0]             io_ledg_o,
    output logic [31:0]             io_lcd_o
);
    localparam int unsigned       c_dm_aw     = $clog2(DMEM_BYTES);
    localparam int unsigned       c_dm_words  = DMEM_BYTES / 4;
    localparam logic [ADDR_W:0]   c_dm_lim    = (ADDR_W+1)'(DMEM_BYTES);
    localparam logic [ADDR_W:0]   c_io_lim    = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W-3:0] c_io_base_w = (ADDR_W-2)'(IO_BASE >> 2);
    localparam logic [ADDR_W-3:0] c_sw_w      = (ADDR_W-2)'(SW_ADDR >> 2);
    localparam logic [ADDR_W-5:0] c_slot_ledr = (ADDR_W-4)'(8);
    localparam logic [ADDR_W-5:0] c_slot_ledg = (ADDR_W-4)'(9);
    localparam logic [ADDR_W-5:0] c_slot_lcd  = (ADDR_W-4)'(10);
    localparam logic [1:0]        c_sz_byte   = 2'b00;
    localparam logic [1:0]        c_sz_half   = 2'b01;
    localparam logic [1:0]        c_sz_word   = 2'b10;

    logic [31:0]              r_dmem [c_dm_words];
    logic [NUM_HEX-1:0][31:0] r_hex;
    logic [31:0]              r_ledr, r_ledg, r_lcd;
    logic [31:0]              r_sw_meta, r_sw_sync;
    logic [31:0]              r_ld_data;
    logic                     r_ld_valid, r_misalign;

    logic [ADDR_W-1:0]        w_addr;
    logic [1:0]               w_lane;
    logic                     w_mis, w_ld, w_st;
    logic                     w_dm_sel, w_sw_sel, w_io_ok;
    logic [ADDR_W-3:0]        w_io_wrel;
    logic [ADDR_W-5:0]        w_slot;
    logic [c_dm_aw-3:0]       w_dm_idx;
    logic [3:0]               w_be;
    logic [31:0]              w_wdata, w_rword, w_shift, w_ld_ext;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

    assign w_addr   = bus.addr_i;
    assign w_lane   = w_addr[1:0];
    assign w_dm_idx = w_addr[c_dm_aw-1:2];

    // I/O slots are decoded on the word address relative to the window base
    assign w_dm_sel  = {1'b0, w_addr} < c_dm_lim;
    assign w_sw_sel  = (w_addr[ADDR_W-1:2] == c_sw_w);
    assign w_io_wrel = w_addr[ADDR_W-1:2] - c_io_base_w;
    assign w_slot    = w_io_wrel[ADDR_W-3:2];
    assign w_io_ok   = ({1'b0, w_addr} >= c_io_lim) && (w_io_wrel[1:0] == 2'b00);

    always_comb begin
        w_mis = 1'b1;
        case (bus.size_i)
            c_sz_byte: w_mis = 1'b0;
            c_sz_half: w_mis = w_addr[0];
            c_sz_word: w_mis = |w_addr[1:0];
            default:   w_mis = 1'b1;
        endcase
    end

    assign w_ld = bus.req_i & ~bus.st_en_i;
    assign w_st = bus.req_i &  bus.st_en_i & ~w_mis;

    // Store data is replicated across lanes so byte enables alone pick the target
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = bus.st_data_i;
        case (bus.size_i)
            c_sz_byte: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{bus.st_data_i[7:0]}};
            end
            c_sz_half: begin
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{bus.st_data_i[15:0]}};
            end
            c_sz_word: w_be = 4'b1111;
            default:   w_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_rword = '0;
        if (w_dm_sel) begin
            w_rword = r_dmem[w_dm_idx];
        end else if (w_sw_sel) begin
            w_rword = r_sw_sync;
        end else if (w_io_ok) begin
            for (int k = 0; k < NUM_HEX; k++)
                if (w_slot == (ADDR_W-4)'(k)) w_rword = r_hex[k];
            if (w_slot == c_slot_ledr) w_rword = r_ledr;
            if (w_slot == c_slot_ledg) w_rword = r_ledg;
            if (w_slot == c_slot_lcd)  w_rword = r_lcd;
        end
    end

    always_comb begin
        w_shift  = w_rword >> {w_lane, 3'b000};
        w_ld_ext = w_shift;
        case (bus.size_i)
            c_sz_byte: w_ld_ext = {{24{~bus.unsigned_i & w_shift[7]}},  w_shift[7:0]};
            c_sz_half: w_ld_ext = {{16{~bus.unsigned_i & w_shift[15]}}, w_shift[15:0]};
            default:   w_ld_ext = w_shift;
        endcase
    end

    // Data memory is intentionally left unreset
    always_ff @(posedge clk_i) begin
        if (w_st && w_dm_sel)
            r_dmem[w_dm_idx] <= f_merge(r_dmem[w_dm_idx], w_wdata, w_be);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hex      <= '0;
            r_ledr     <= '0;
            r_ledg     <= '0;
            r_lcd      <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_ld_data  <= '0;
            r_ld_valid <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_sw_meta  <= io_sw_i;
            r_sw_sync  <= r_sw_meta;
            r_ld_valid <= w_ld;
            r_misalign <= bus.req_i & w_mis;
            if (w_ld)
                r_ld_data <= w_mis ? '0 : w_ld_ext;
            if (w_st && w_io_ok) begin
                for (int k = 0; k < NUM_HEX; k++)
                    if (w_slot == (ADDR_W-4)'(k)) r_hex[k] <= f_merge(r_hex[k], w_wdata, w_be);
                if (w_slot == c_slot_ledr) r_ledr <= f_merge(r_ledr, w_wdata, w_be);
                if (w_slot == c_slot_ledg) r_ledg <= f_merge(r_ledg, w_wdata, w_be);
                if (w_slot == c_slot_lcd)  r_lcd  <= f_merge(r_lcd,  w_wdata, w_be);
            end
        end
    end

    assign bus.ld_data_o  = r_ld_data;
    assign bus.ld_valid_o = r_ld_valid;
    assign bus.misalign_o = r_misalign;
    assign io_hex_o       = r_hex;
    assign io_ledr_o      = r_ledr;
    assign io_ledg_o      = r_ledg;
    assign io_lcd_o       = r_lcd;
endmodule
`default_nettype wire
